// File: rtl/mult_pkg.sv
// Shared types and helpers for the handshaked sequential multiplier.
package mult_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int MAX_W = 64;

  function automatic int iter_count(input int width, input int step);
    return width / step;
  endfunction

  // Caller sign- or zero-extends to MAX_W; the magnitude of the most negative value stays exact.
  function automatic logic [MAX_W-1:0] abs_w(input logic [MAX_W-1:0] value, input logic is_signed);
    if (is_signed && value[MAX_W-1])
      return ~value + 1'b1;
    return value;
  endfunction

endpackage

// File: rtl/mult_step.sv
// One shift-add iteration: retires STEP multiplier bits from the low end of acc.
// Purely combinational; no backpressure.
module mult_step #(
  parameter int WIDTH = 16,
  parameter int STEP  = 1
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   a_mag,
  output logic [2*WIDTH-1:0] acc_nxt
);

  logic [STEP-1:0]    chunk;
  logic [WIDTH+STEP:0] sum;

  assign chunk = acc[STEP-1:0];
  assign sum   = (WIDTH+STEP+1)'(acc[2*WIDTH-1:WIDTH])
               + (WIDTH+STEP+1)'(a_mag) * (WIDTH+STEP+1)'(chunk);

  // Partial product never reaches the top bit of sum, so dropping it is lossless.
  assign acc_nxt = (2*WIDTH)'({sum, acc[WIDTH-1:STEP]});

endmodule

// File: rtl/seq_mult_hs.sv
// Sequential signed/unsigned multiplier, WIDTH/STEP cycles per op, one op in flight.
// out_valid rises WIDTH/STEP edges after accept; result held in DONE until out_ready.
module seq_mult_hs
  import mult_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               busy
);

  localparam int N  = iter_count(WIDTH, STEP);
  localparam int CW = $clog2(N + 1);

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0]   a_mag;
  logic               neg;
  logic [MAX_W-1:0]   a_ext, b_ext;
  logic               accept, last;

  assign a_ext = {{(MAX_W-WIDTH){is_signed & a[WIDTH-1]}}, a};
  assign b_ext = {{(MAX_W-WIDTH){is_signed & b[WIDTH-1]}}, b};

  assign in_ready  = (state == IDLE) && !reset;
  assign accept    = in_valid && in_ready;
  assign last      = (cnt == CW'(1));
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  mult_step #(.WIDTH(WIDTH), .STEP(STEP)) u_step (
    .acc     (acc),
    .a_mag   (a_mag),
    .acc_nxt (acc_nxt)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      acc    <= '0;
      a_mag  <= '0;
      neg    <= 1'b0;
      result <= '0;
    end else if (accept) begin
      cnt   <= CW'(N);
      a_mag <= WIDTH'(abs_w(a_ext, is_signed));
      acc   <= {{WIDTH{1'b0}}, WIDTH'(abs_w(b_ext, is_signed))};
      neg   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if (state == RUN) begin
      acc <= acc_nxt;
      cnt <= cnt - CW'(1);
      // Sign is applied once, on the final iteration, so result only changes on DONE entry.
      if (last) result <= neg ? -acc_nxt : acc_nxt;
    end
  end

endmodule

// File: doc/seq_mult_hs.md
Name: seq_mult_hs

Overview:
- Iterative shift-add multiplier: next generation of the team's sequential multiplier.
- Adds configurable operand width and radix (bits retired per cycle), a per-operation signed/unsigned mode, and valid/ready handshakes on both input and output.
- Sits between a command producer and a result consumer in the datapath; exactly one operation is in flight at a time.

Parameters:
- WIDTH, 16, operand width in bits; even and ≥4.
- STEP, 1, multiplier bits retired per cycle; one of 1, 2 or 4; must divide WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  producer presents an operation.
- in_ready  out  1  block can accept an operation.
- a  in  WIDTH  multiplicand.
- b  in  WIDTH  multiplier.
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled with a and b.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.
- result  out  2*WIDTH  product; signed or unsigned as selected at accept time.
- busy  out  1  high in RUN and DONE.

Behaviour:
- N = WIDTH/STEP iterations; the counter is $clog2(N+1) bits wide.
- FSM has three states: IDLE, RUN and DONE. Reset state is IDLE.
- Output reset values:
  - out_valid = 0, result = 0, busy = 0.
  - in_ready = 0 while reset is asserted.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready at edge k: latch the operands, load the counter with N, go to RUN.
  - Operand latching: a_mag = |a| and b_mag = |b| when is_signed, otherwise a and b unchanged.
  - neg = is_signed & (a[MSB] ^ b[MSB]).
  - Accumulator = {0, b_mag}.
- RUN, once per cycle:
  - chunk = acc[STEP-1:0].
  - Compute the upper half + a_mag*chunk at WIDTH+STEP+1 bits.
  - Shift the accumulator right by STEP; decrement the counter.
  - When the counter reaches 0 after the update, go to DONE.
  - In the same edge, register result = neg ? -acc : acc, truncated to 2*WIDTH.
- Latency: out_valid rises after edge k+N. Example: WIDTH=16, STEP=1 gives 16 cycles; STEP=4 gives 4 cycles.
- DONE:
  - out_valid = 1; result held stable.
  - in_ready = 0; in_valid is ignored.
  - On out_ready: go to IDLE; out_valid drops the next cycle.
  - result keeps its last value until the next DONE entry.
- Handshakes follow the usual valid/ready rules: a transfer occurs only when both signals are high at a clock edge. out_valid never drops without out_ready.
- Signed edge cases:
  - The magnitude of -2^(WIDTH-1) is representable unsigned.
  - (-2^(W-1))*(-2^(W-1)) = 2^(2W-2) fits in the 2W-bit signed result.
- Zero operands complete in the full N cycles; there is no early termination.
- Throughput: one operation per N+2 cycles when out_ready is held high.
- Reset asserted mid-RUN or mid-DONE aborts the operation immediately. No stale out_valid appears after reset is released.
- a, b and is_signed are don't-care outside the accepting edge.

Decomposition:
- Package mult_pkg:
  - state_t enum {IDLE, RUN, DONE}.
  - Function abs_w(value, is_signed).
  - Localparam helper for the iteration count.
- One sub-module, mult_step: combinational single-iteration datapath (add a_mag*chunk, shift right by STEP), parametrised by WIDTH and STEP. The top level holds the FSM, counter and registers.

Test Plan:
- WIDTH=16, STEP=1, unsigned: a=0xFFFF, b=0xFFFF, out_ready=1 → out_valid exactly 16 cycles after accept; result=0xFFFE0001; in_ready low throughout.
- WIDTH=16, STEP=4, signed: a=-3 (0xFFFD), b=7 → result=0xFFFFFFEB (-21) after 4 cycles. Then a=0x8000, b=0x8000 signed → result=0x40000000.
- Backpressure: hold out_ready=0 for 10 cycles in DONE, with in_valid=1 and new operands → result and out_valid stable, in_ready=0. Release → one transfer, then the new operation is accepted in IDLE.
- Mode mix: a=0x8000, b=2 with is_signed=0 → 0x00010000; the same operands with is_signed=1 → 0xFFFF0000.
- Reset mid-RUN at iteration 5 → out_valid=0, result=0 immediately. After release, in_ready=1 and a fresh 3*5 returns 15 with no spurious out_valid beforehand.
- Randomized: 1000 ops over STEP∈{1,2,4} with random in_valid/out_ready stalls; every result checked against a reference model (a*b) ordered by handshake; no lost or duplicated results.
